// File: rtl/embedded_system_jtag_debug_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | embedded_system_jtag_debug_cmd_queue: synchronised JTAG update events,   |
// | FIFO-buffered, decoded into one-hot OCI strobes.   Rev 1.0               |
// +--------------------------------------------------------------------------+
module embedded_system_jtag_debug_cmd_queue #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DATA_W-1:0]        sr,
  input  logic                     cmd_ready,
  input  logic                     ovf_clr,
  output logic                     cmd_valid,
  output logic                     cmd_kind,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [DATA_W-1:0]        jdo,
  output logic [2**IR_W-1:0]       take_action,
  output logic [2**IR_W-1:0]       take_no_action,
  output logic                     ir_update,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     overflow
);

  localparam int c_aw  = $clog2(DEPTH);
  localparam int c_nch = 2**IR_W;
  localparam int c_ew  = 1 + IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_dly_q, uir_dly_q;
  logic                   pend_q, pend_d;
  logic [IR_W-1:0]        pend_ir_q, pend_ir_d;
  logic [c_aw-1:0]        wr_ptr_q, rd_ptr_q;
  logic [c_aw:0]          count_q, count_d;
  logic [c_ew-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [c_nch-1:0]       ta_q, ta_d, tna_q, tna_d;
  logic                   iru_q, iru_d;
  logic                   ovf_q, ovf_d;

  logic                   udr_edge, uir_edge;
  logic                   wr_req, push, pop, full, empty, drop;
  logic [c_ew-1:0]        wr_entry, head;
  logic                   head_kind;
  logic [IR_W-1:0]        head_ir;
  logic [DATA_W-1:0]      head_data;

  assign udr_edge  = udr_sync_q[SYNC_STAGES-1] & ~udr_dly_q;
  assign uir_edge  = uir_sync_q[SYNC_STAGES-1] & ~uir_dly_q;

  assign head      = mem_q[rd_ptr_q];
  assign head_kind = head[c_ew-1];
  assign head_ir   = head[DATA_W +: IR_W];
  assign head_data = head[DATA_W-1:0];

  assign empty = (count_q == '0);
  assign full  = (count_q == (c_aw+1)'(DEPTH));
  assign pop   = ~empty & cmd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign push  = wr_req & (~full | pop);
  assign drop  = wr_req & full & ~pop;

  // UDR takes the write port first; a coincident UIR waits one cycle in pend_q.
  always_comb begin
    wr_req    = 1'b0;
    wr_entry  = '0;
    pend_d    = pend_q;
    pend_ir_d = pend_ir_q;
    if (udr_edge) begin
      wr_req   = 1'b1;
      wr_entry = {1'b1, ir_in, sr};
      if (uir_edge) begin
        pend_d    = 1'b1;
        pend_ir_d = ir_in;
      end
    end else if (pend_q) begin
      wr_req    = 1'b1;
      wr_entry  = {1'b0, pend_ir_q, {DATA_W{1'b0}}};
      pend_d    = uir_edge;
      pend_ir_d = ir_in;
    end else if (uir_edge) begin
      wr_req   = 1'b1;
      wr_entry = {1'b0, ir_in, {DATA_W{1'b0}}};
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (c_aw+1)'(1);
      2'b01:   count_d = count_q - (c_aw+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    jdo_d = jdo_q;
    ta_d  = '0;
    tna_d = '0;
    iru_d = 1'b0;
    if (pop) begin
      if (head_kind) begin
        jdo_d = head_data;
        if (head_data[DATA_W-1]) ta_d[head_ir]  = 1'b1;
        else                     tna_d[head_ir] = 1'b1;
      end else begin
        iru_d = 1'b1;
      end
    end
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_dly_q  <= 1'b0;
      uir_dly_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_ir_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      jdo_q      <= '0;
      ta_q       <= '0;
      tna_q      <= '0;
      iru_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_dly_q  <= udr_sync_q[SYNC_STAGES-1];
      uir_dly_q  <= uir_sync_q[SYNC_STAGES-1];
      pend_q     <= pend_d;
      pend_ir_q  <= pend_ir_d;
      if (push) wr_ptr_q <= wr_ptr_q + c_aw'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + c_aw'(1);
      count_q    <= count_d;
      jdo_q      <= jdo_d;
      ta_q       <= ta_d;
      tna_q      <= tna_d;
      iru_q      <= iru_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage needs no reset: stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign cmd_valid      = ~empty;
  assign cmd_kind       = ~empty & head_kind;
  assign cmd_ir         = empty ? '0 : head_ir;
  assign jdo            = jdo_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign ir_update      = iru_q;
  assign fill_level     = count_q;
  assign overflow       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_embedded_system_jtag_debug_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_embedded_system_jtag_debug_cmd_queue: directed vectors with           |
// | hand-computed expectations.   Rev 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_embedded_system_jtag_debug_cmd_queue;

  logic        clk = 1'b0;
  logic        reset_n, vs_udr, vs_uir, cmd_ready, ovf_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, cmd_kind, ir_update, overflow;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fill_level;

  int n_vec = 0;
  int n_err = 0;

  embedded_system_jtag_debug_cmd_queue dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .cmd_kind(cmd_kind), .cmd_ir(cmd_ir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .fill_level(fill_level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold levels 3 cycles (write lands on the 3rd edge), then low 3 cycles.
  task automatic ev(input logic u, input logic i, input logic [1:0] ir, input logic [37:0] d);
    vs_udr = u; vs_uir = i; ir_in = ir; sr = d;
    repeat (3) tick();
    vs_udr = 1'b0; vs_uir = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0;
    ovf_clr = 1'b0; ir_in = '0; sr = '0;
    repeat (3) tick();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_kind",  cmd_kind, 0);
    chk("rst_ir",    cmd_ir, 0);
    chk("rst_jdo",   jdo, 0);
    chk("rst_ta",    take_action, 0);
    chk("rst_tna",   take_no_action, 0);
    chk("rst_iru",   ir_update, 0);
    chk("rst_fill",  fill_level, 0);
    chk("rst_ovf",   overflow, 0);
    reset_n = 1'b1;
    tick();

    // Single UDR with action flag set
    ir_in = 2'b01; sr = 38'h20_0000_00AB; cmd_ready = 1'b1; vs_udr = 1'b1;
    tick(); chk("s_e0_valid", cmd_valid, 0);
    tick(); chk("s_e1_valid", cmd_valid, 0);
    tick(); chk("s_e2_valid", cmd_valid, 1);
    chk("s_e2_kind", cmd_kind, 1);
    chk("s_e2_ir",   cmd_ir, 2'b01);
    chk("s_e2_fill", fill_level, 1);
    tick(); chk("s_ta",  take_action, 4'b0010);
    chk("s_jdo",  jdo, 38'h20_0000_00AB);
    chk("s_tna",  take_no_action, 0);
    chk("s_fill", fill_level, 0);
    tick(); chk("s_ta_end", take_action, 0);
    vs_udr = 1'b0;
    repeat (4) tick();

    // No-action strobe
    ir_in = 2'b11; sr = 38'h0_0000_1234; vs_udr = 1'b1;
    repeat (4) tick();
    chk("na_tna", take_no_action, 4'b1000);
    chk("na_ta",  take_action, 0);
    chk("na_jdo", jdo, 38'h0_0000_1234);
    tick(); chk("na_tna_end", take_no_action, 0);
    vs_udr = 1'b0;
    repeat (4) tick();

    // Backpressure and overflow
    cmd_ready = 1'b0;
    for (int k = 1; k <= 4; k++) ev(1'b1, 1'b0, 2'b10, 38'(k));
    chk("bp_fill4", fill_level, 4);
    chk("bp_ovf0",  overflow, 0);
    ev(1'b1, 1'b0, 2'b10, 38'd5);
    chk("bp_fill_full", fill_level, 4);
    chk("bp_ovf1",      overflow, 1);
    cmd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("bp_jdo", jdo, 38'(k));
      chk("bp_tna", take_no_action, 4'b0100);
    end
    cmd_ready = 1'b0;
    tick();
    chk("bp_empty", fill_level, 0);
    chk("bp_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("bp_ovf_clr", overflow, 0);

    // Coincident UDR and UIR edges
    ev(1'b1, 1'b1, 2'b01, 38'h20_0000_0055);
    chk("sim_fill", fill_level, 2);
    chk("sim_kind0", cmd_kind, 1);
    cmd_ready = 1'b1;
    tick();
    chk("sim_ta",   take_action, 4'b0010);
    chk("sim_iru0", ir_update, 0);
    chk("sim_jdo",  jdo, 38'h20_0000_0055);
    chk("sim_kind1", cmd_kind, 0);
    chk("sim_ir1",   cmd_ir, 2'b01);
    tick();
    chk("sim_iru1", ir_update, 1);
    chk("sim_ta_end", take_action, 0);
    chk("sim_jdo_hold", jdo, 38'h20_0000_0055);
    cmd_ready = 1'b0;
    tick();
    chk("sim_iru_end", ir_update, 0);
    chk("sim_empty", cmd_valid, 0);

    // Push and pop together while full
    for (int k = 0; k < 4; k++) ev(1'b1, 1'b0, 2'b00, 38'h11 + 38'(k));
    chk("fp_fill4", fill_level, 4);
    sr = 38'h15; vs_udr = 1'b1;
    tick(); tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("fp_fill", fill_level, 4);
    chk("fp_jdo",  jdo, 38'h11);
    tick();
    chk("fp_ovf", overflow, 0);
    vs_udr = 1'b0;
    repeat (3) tick();
    cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fp_order", jdo, 38'h12 + 38'(k));
    end
    cmd_ready = 1'b0;
    tick();
    chk("fp_empty", fill_level, 0);
    chk("fp_ovf_end", overflow, 0);

    // Reset mid-traffic, with vs_udr held high across release
    for (int k = 0; k < 4; k++) ev(1'b1, 1'b0, 2'b11, 38'h21 + 38'(k));
    cmd_ready = 1'b1;
    tick();
    chk("r_pre_tna",  take_no_action, 4'b1000);
    chk("r_pre_fill", fill_level, 3);
    cmd_ready = 1'b0; reset_n = 1'b0; vs_udr = 1'b1; sr = 38'h30;
    tick();
    chk("r_valid", cmd_valid, 0);
    chk("r_fill",  fill_level, 0);
    chk("r_tna",   take_no_action, 0);
    chk("r_ta",    take_action, 0);
    chk("r_jdo",   jdo, 0);
    chk("r_iru",   ir_update, 0);
    chk("r_ovf",   overflow, 0);
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    chk("r_one_evt", fill_level, 1);
    chk("r_no_stale", take_no_action, 0);
    cmd_ready = 1'b1;
    tick();
    chk("r_evt_jdo", jdo, 38'h30);
    chk("r_evt_tna", take_no_action, 4'b1000);
    cmd_ready = 1'b0; vs_udr = 1'b0;
    repeat (4) tick();
    chk("r_final_fill", fill_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/embedded_system_jtag_debug_cmd_queue.md
# embedded_system_jtag_debug_cmd_queue

Parametrised system-clock-side command receiver for the Nios II JTAG debug path. It synchronises the virtual-JTAG update strobes, captures the instruction and scan data, and buffers each event in a FIFO. Per-instruction one-hot action / no-action strobes are issued to the OCI debug logic under a valid/ready handshake. It sits between the TCK-domain shift logic and the OCI blocks, and generalises fixed 2-bit-IR, unbuffered decoding to arbitrary IR width, data width and queue depth.

## Interface
- DATA_W, 38, scan data width; bit DATA_W-1 is the action flag
- IR_W, 2, virtual IR width; 2**IR_W strobe channels
- DEPTH, 4, FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, synchroniser flops per strobe; ≥2
- Clocking/reset: one clock; reset is synchronous and active-low.
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- vs_udr  in  1  update-DR level from TCK domain, asynchronous
- vs_uir  in  1  update-IR level from TCK domain, asynchronous
- ir_in  in  IR_W  current virtual IR; quasi-static while vs_udr/vs_uir high
- sr  in  DATA_W  scan register; quasi-static while vs_udr high
- cmd_ready  in  1  consumer accepts head entry
- ovf_clr  in  1  clears sticky overflow
- cmd_valid  out  1  FIFO non-empty
- cmd_kind  out  1  head entry type: 1=UDR data, 0=UIR update
- cmd_ir  out  IR_W  head entry IR
- jdo  out  DATA_W  data of last accepted UDR entry
- take_action  out  2**IR_W  one-hot pulse, accepted UDR with flag=1
- take_no_action  out  2**IR_W  one-hot pulse, accepted UDR with flag=0
- ir_update  out  1  pulse, accepted UIR entry
- fill_level  out  $clog2(DEPTH)+1  entries held
- overflow  out  1  sticky: an event was dropped

## Operation
- Each of vs_udr and vs_uir passes through a SYNC_STAGES flop chain plus one delay flop. A rising edge is sync_last & ~delay.
- UDR edge: enqueue {kind=1, ir_in, sr}, sampled on the same edge as the write. UIR edge: enqueue {kind=0, ir_in, data=0}.
- Simultaneous UDR and UIR edges: the UDR entry is written first. The UIR entry is held in a one-entry pending register and written on the next cycle. Further edges are not possible while pending.
- Full FIFO at write time: the entry is dropped and overflow is set. ovf_clr clears overflow; a set in the same cycle wins.
- FIFO is show-ahead. cmd_valid, cmd_kind and cmd_ir reflect the head entry. Handshake = cmd_valid & cmd_ready.
- On handshake, the entry is popped and registered on that edge:
  - kind=1: jdo ← data. take_action[ir] if data[DATA_W-1]=1, otherwise take_no_action[ir].
  - kind=0: ir_update; jdo unchanged.
- Simultaneous push and pop is allowed at any level, including full: when full, a pop in the same cycle makes room and no overflow occurs. fill_level is unchanged.
- Pointers wrap modulo DEPTH. fill_level counts 0..DEPTH.
- Reset (any time): sync/delay/pending flops cleared; FIFO flushed; all outputs 0. A vs_udr level held high across reset release produces exactly one event.

## Timing
- Reset values: cmd_valid, cmd_kind, cmd_ir, jdo, take_action, take_no_action, ir_update, fill_level and overflow all 0.
- Let E0 be the first edge at which sync stage 0 captures 1. The FIFO write happens at E(SYNC_STAGES); cmd_valid is high after that edge (E2 for default).
- Strobes and jdo are registered. Each strobe is high for exactly the one cycle following the handshake edge, and deasserts unless another handshake occurs.
- Back-to-back handshakes give strobes on consecutive cycles.
- Minimum event spacing: SYNC_STAGES+1 cycles low between levels. Shorter pulses may be missed; this is not checked.
- overflow rises on the cycle after the dropped write.

## Test plan
- Single UDR: ir_in=2'b01, sr=38'h20_0000_00AB, cmd_ready=1 → cmd_valid high after E2, jdo=38'h20_0000_00AB and take_action=4'b0010 for one cycle, fill_level back to 0.
- No-action: ir_in=2'b11, sr=38'h0_0000_1234 → take_no_action=4'b1000 one pulse, take_action stays 0.
- Backpressure: cmd_ready=0, five UDR events (sr=1..5) → fill_level=4 and overflow=1; drain yields jdo 1,2,3,4 in order; ovf_clr → overflow=0.
- Simultaneous UDR+UIR edges → two entries (kind 1 then kind 0); ir_update pulses after the UDR strobe; jdo holds the UDR data.
- Full with push+pop in same cycle → fill_level stays 4, overflow stays 0, order preserved.
- reset_n=0 with 3 entries queued and a strobe active → next cycle: all outputs 0, fill_level=0; no stale strobe after release.
